// File: rtl/hart_mem_arbiter.sv
// hart_mem_arbiter: shares one single-port word RAM between the fetch and load/store ports.
// Define MEM_ARB_ROUND_ROBIN_EN to break simultaneous-request ties round-robin instead of ls-first.
module hart_mem_arbiter #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [XLEN-1:0]   if_req_addr,
  output logic              if_rsp_valid,
  output logic [XLEN-1:0]   if_rsp_data,
  output logic              if_rsp_err,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic [XLEN-1:0]   ls_req_addr,
  input  logic              ls_req_we,
  input  logic [1:0]        ls_req_size,
  input  logic              ls_req_unsigned,
  input  logic [XLEN-1:0]   ls_req_wdata,
  output logic              ls_rsp_valid,
  output logic [XLEN-1:0]   ls_rsp_data,
  output logic              ls_rsp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  state_t state_reg, state_next;

  logic              prefer_ls;
  logic              idle;
  logic              grant_ls;
  logic              grant_if;
  logic              accept;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic [1:0]        req_lane;
  logic              req_we;
  logic              req_legal;

  logic              owner_ls_reg;
  logic              err_reg;
  logic              we_reg;
  logic              unsigned_reg;
  logic [1:0]        size_reg;
  logic [1:0]        lane_reg;

  logic [XLEN-1:0]   lane_data;
  logic [XLEN-1:0]   rsp_word;

  logic              if_rsp_valid_reg;
  logic [XLEN-1:0]   if_rsp_data_reg;
  logic              if_rsp_err_reg;
  logic              ls_rsp_valid_reg;
  logic [XLEN-1:0]   ls_rsp_data_reg;
  logic              ls_rsp_err_reg;

  // Address bits above the RAM window are ignored so accesses wrap.
  logic              unused_bits;
  assign unused_bits = ^{ls_req_addr[XLEN-1:ADDR_W], if_req_addr[XLEN-1:ADDR_W],
                         lane_data[XLEN-1:16]};

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_ls_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      last_ls_reg <= 1'b0;
    end else if (accept) begin
      last_ls_reg <= grant_ls;
    end
  end

  assign prefer_ls = !last_ls_reg;
`else
  assign prefer_ls = 1'b1;
`endif

  // Readies are forced low while reset is asserted even though the state is already IDLE.
  assign idle     = (state_reg == IDLE) && !reset;
  assign grant_ls = idle && ls_req_valid && (prefer_ls || !if_req_valid);
  assign grant_if = idle && if_req_valid && !grant_ls;
  assign accept   = grant_ls || grant_if;

  assign ls_req_ready = grant_ls;
  assign if_req_ready = grant_if;

  assign req_addr = grant_ls ? ls_req_addr[ADDR_W-1:0] : if_req_addr[ADDR_W-1:0];
  assign req_size = grant_ls ? ls_req_size : SZ_W;
  assign req_we   = grant_ls && ls_req_we;
  assign req_lane = req_addr[1:0];

  always_comb begin
    req_legal = 1'b0;
    case (req_size)
      SZ_B:    req_legal = 1'b1;
      SZ_H:    req_legal = !req_addr[0];
      SZ_W:    req_legal = (req_addr[1:0] == 2'b00);
      default: req_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wstrb  = 4'b0000;
    mem_wdata  = '0;

    case (state_reg)
      IDLE:    if (accept) state_next = WAIT;
      WAIT:    state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    if (accept && req_legal) begin
      mem_en   = 1'b1;
      mem_addr = req_addr[ADDR_W-1:2];
      if (req_we) begin
        mem_we = 1'b1;
        case (req_size)
          SZ_B: begin
            mem_wstrb = 4'b0001 << req_lane;
            mem_wdata = XLEN'(ls_req_wdata[7:0]) << {req_lane, 3'b000};
          end
          SZ_H: begin
            mem_wstrb = 4'b0011 << req_lane;
            mem_wdata = XLEN'(ls_req_wdata[15:0]) << {req_lane, 3'b000};
          end
          default: begin
            mem_wstrb = 4'b1111;
            mem_wdata = ls_req_wdata;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      owner_ls_reg <= 1'b0;
      err_reg      <= 1'b0;
      we_reg       <= 1'b0;
      unsigned_reg <= 1'b0;
      size_reg     <= SZ_W;
      lane_reg     <= 2'b00;
    end else if (accept) begin
      owner_ls_reg <= grant_ls;
      err_reg      <= !req_legal;
      we_reg       <= req_we;
      unsigned_reg <= grant_ls && ls_req_unsigned;
      size_reg     <= req_size;
      lane_reg     <= req_lane;
    end
  end

  // Lane select and extension of the word returned one cycle after the strobe.
  always_comb begin
    lane_data = mem_rdata >> {lane_reg, 3'b000};
    rsp_word  = mem_rdata;
    case (size_reg)
      SZ_B: rsp_word = unsigned_reg ? {{(XLEN-8){1'b0}}, lane_data[7:0]}
                                    : {{(XLEN-8){lane_data[7]}}, lane_data[7:0]};
      SZ_H: rsp_word = unsigned_reg ? {{(XLEN-16){1'b0}}, lane_data[15:0]}
                                    : {{(XLEN-16){lane_data[15]}}, lane_data[15:0]};
      default: rsp_word = mem_rdata;
    endcase
    if (err_reg || we_reg) begin
      rsp_word = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      if_rsp_valid_reg <= 1'b0;
      if_rsp_data_reg  <= '0;
      if_rsp_err_reg   <= 1'b0;
      ls_rsp_valid_reg <= 1'b0;
      ls_rsp_data_reg  <= '0;
      ls_rsp_err_reg   <= 1'b0;
    end else begin
      if_rsp_valid_reg <= 1'b0;
      ls_rsp_valid_reg <= 1'b0;
      if (state_reg == WAIT) begin
        if (owner_ls_reg) begin
          ls_rsp_valid_reg <= 1'b1;
          ls_rsp_data_reg  <= rsp_word;
          ls_rsp_err_reg   <= err_reg;
        end else begin
          if_rsp_valid_reg <= 1'b1;
          if_rsp_data_reg  <= rsp_word;
          if_rsp_err_reg   <= err_reg;
        end
      end
    end
  end

  assign if_rsp_valid = if_rsp_valid_reg;
  assign if_rsp_data  = if_rsp_data_reg;
  assign if_rsp_err   = if_rsp_err_reg;
  assign ls_rsp_valid = ls_rsp_valid_reg;
  assign ls_rsp_data  = ls_rsp_data_reg;
  assign ls_rsp_err   = ls_rsp_err_reg;

endmodule

// File: tb/tb_hart_mem_arbiter.sv
// Bench for hart_mem_arbiter: byte-array memory model, directed scenarios and random traffic.
module tb_hart_mem_arbiter;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        if_req_valid, if_req_ready;
  logic [31:0] if_req_addr;
  logic        if_rsp_valid, if_rsp_err;
  logic [31:0] if_rsp_data;
  logic        ls_req_valid, ls_req_ready, ls_req_we, ls_req_unsigned;
  logic [31:0] ls_req_addr, ls_req_wdata;
  logic [1:0]  ls_req_size;
  logic        ls_rsp_valid, ls_rsp_err;
  logic [31:0] ls_rsp_data;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata, mem_rdata;

  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [31:0] pl_data;

  logic [31:0] ram [0:255];
  logic [7:0]  mb  [0:1023];

  int check_count;
  int pass_count;

  typedef struct packed {
    logic        ok;
    logic        en;
    logic        we;
    logic [7:0]  maddr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic        early;
    logic        rv;
    logic        other;
    logic [31:0] data;
    logic        err;
    logic        late;
  } obs_t;

  hart_mem_arbiter #(.XLEN(32), .ADDR_W(10)) dut (
    .clock(clock), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_addr(ls_req_addr),
    .ls_req_we(ls_req_we), .ls_req_size(ls_req_size), .ls_req_unsigned(ls_req_unsigned),
    .ls_req_wdata(ls_req_wdata),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data), .ls_rsp_err(ls_rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single-port RAM with a side preload port used only by the bench.
  always @(posedge clock) begin
    if (pl_en) begin
      ram[pl_addr] <= pl_data;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      mem_rdata <= ram[mem_addr];
    end
  end

  function automatic logic legal_of(input logic [1:0] sz, input logic [31:0] a);
    case (sz)
      2'd0:    return 1'b1;
      2'd1:    return !a[0];
      2'd2:    return a[1:0] == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int nbytes_of(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] sz, input logic uns, input logic [31:0] a);
    logic [31:0] v;
    int b;
    int nb;
    b  = int'(a[9:0]);
    nb = nbytes_of(sz);
    v  = 32'd0;
    for (int k = 0; k < nb; k++) v[8*k +: 8] = mb[b + k];
    if (!uns && nb == 1) v = {{24{v[7]}}, v[7:0]};
    if (!uns && nb == 2) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic preload(input int w, input logic [31:0] d);
    @(posedge clock); #1;
    pl_en = 1'b1; pl_addr = 8'(w); pl_data = d;
    @(posedge clock); #1;
    pl_en = 1'b0;
    for (int k = 0; k < 4; k++) mb[4*w + k] = d[8*k +: 8];
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1; ls_req_valid = 1'b0; if_req_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Drives one request, waits (bounded) for acceptance and records what the DUT did.
  task automatic txn(input logic use_ls, input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] wd, output obs_t o);
    o = '0;
    @(posedge clock); #1;
    if (use_ls) begin
      ls_req_valid = 1'b1; ls_req_addr = a; ls_req_we = we; ls_req_size = sz;
      ls_req_unsigned = uns; ls_req_wdata = wd;
    end else begin
      if_req_valid = 1'b1; if_req_addr = a;
    end
    for (int c = 0; c < 20 && !o.ok; c++) begin
      #1;
      if (use_ls ? ls_req_ready : if_req_ready) begin
        o.ok = 1'b1; o.en = mem_en; o.we = mem_we; o.maddr = mem_addr;
        o.strb = mem_wstrb; o.wdata = mem_wdata;
      end else begin
        @(posedge clock); #1;
      end
    end
    @(posedge clock); #1;
    ls_req_valid = 1'b0; if_req_valid = 1'b0;
    if (o.ok) begin
      o.early = ls_rsp_valid | if_rsp_valid;
      @(posedge clock); #1;
      o.rv    = use_ls ? ls_rsp_valid : if_rsp_valid;
      o.other = use_ls ? if_rsp_valid : ls_rsp_valid;
      o.data  = use_ls ? ls_rsp_data : if_rsp_data;
      o.err   = use_ls ? ls_rsp_err : if_rsp_err;
      @(posedge clock); #1;
      o.late  = ls_rsp_valid | if_rsp_valid;
    end
    $display("txn port=%s we=%0b size=%0d uns=%0b addr=%h wdata=%h -> acc=%0b en=%0b strb=%b data=%h err=%0b",
             use_ls ? "ls" : "if", we, sz, uns, a, wd, o.ok, o.en, o.strb, o.data, o.err);
  endtask

  task automatic test_reset();
    @(posedge clock); #1;
    ls_req_valid = 1'b1; if_req_valid = 1'b1; ls_req_addr = 32'h0; if_req_addr = 32'h0;
    #1;
    check_count++;
    if ({ls_req_ready, if_req_ready} !== 2'b00) $display("FAIL reset_ready got %b want 00", {ls_req_ready, if_req_ready});
    else pass_count++;
    check_count++;
    if (mem_en !== 1'b0) $display("FAIL reset_mem_en got %b want 0", mem_en);
    else pass_count++;
    check_count++;
    if ({ls_rsp_valid, if_rsp_valid, ls_rsp_err, if_rsp_err} !== 4'b0000 || ls_rsp_data !== 32'h0 || if_rsp_data !== 32'h0)
      $display("FAIL reset_rsp got v=%b%b e=%b%b d=%h/%h want all 0", ls_rsp_valid, if_rsp_valid, ls_rsp_err, if_rsp_err, ls_rsp_data, if_rsp_data);
    else pass_count++;
    ls_req_valid = 1'b0; if_req_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_fetch();
    obs_t o;
    preload(0, 32'h00500793);
    txn(1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, o);
    check_count++;
    if (!(o.ok && o.en && !o.early && o.rv && !o.late)) $display("FAIL fetch0_timing got acc=%b en=%b early=%b rv=%b late=%b want 1 1 0 1 0", o.ok, o.en, o.early, o.rv, o.late);
    else pass_count++;
    check_count++;
    if (o.data !== 32'h00500793 || o.err !== 1'b0) $display("FAIL fetch0_data got %h err=%b want 00500793 err=0", o.data, o.err);
    else pass_count++;
    check_count++;
    if (o.we !== 1'b0 || o.strb !== 4'b0000) $display("FAIL fetch0_nowrite got we=%b strb=%b want 0 0000", o.we, o.strb);
    else pass_count++;
  endtask

  task automatic test_store_load_bytes();
    obs_t o;
    txn(1'b1, 1'b1, 2'd2, 1'b0, 32'h60, 32'h0000000A, o);
    check_count++;
    if (o.strb !== 4'b1111 || o.maddr !== 8'h18 || o.we !== 1'b1) $display("FAIL sw_mem got strb=%b addr=%h we=%b want 1111 18 1", o.strb, o.maddr, o.we);
    else pass_count++;
    check_count++;
    if (!o.rv || o.data !== 32'h0 || o.err !== 1'b0) $display("FAIL sw_rsp got rv=%b data=%h err=%b want 1 0 0", o.rv, o.data, o.err);
    else pass_count++;
    preload(32'h18, 32'h80FF00AA);
    txn(1'b1, 1'b0, 2'd0, 1'b0, 32'h63, 32'h0, o);
    check_count++;
    if (o.data !== 32'hFFFFFF80 || o.err !== 1'b0) $display("FAIL lb_sign got %h err=%b want ffffff80 err=0", o.data, o.err);
    else pass_count++;
    txn(1'b1, 1'b0, 2'd0, 1'b1, 32'h63, 32'h0, o);
    check_count++;
    if (o.data !== 32'h00000080 || o.err !== 1'b0) $display("FAIL lbu_zero got %h err=%b want 00000080 err=0", o.data, o.err);
    else pass_count++;
  endtask

  task automatic test_half();
    obs_t o;
    txn(1'b1, 1'b1, 2'd1, 1'b0, 32'h62, 32'h00001234, o);
    check_count++;
    if (o.strb !== 4'b1100 || o.wdata !== 32'h12340000) $display("FAIL sh_lane got strb=%b wdata=%h want 1100 12340000", o.strb, o.wdata);
    else pass_count++;
    for (int k = 0; k < 2; k++) mb[32'h62 + k] = 8'(32'h1234 >> (8*k));
    txn(1'b1, 1'b0, 2'd1, 1'b0, 32'h61, 32'h0, o);
    check_count++;
    if (o.en !== 1'b0 || !o.rv || o.err !== 1'b1 || o.data !== 32'h0) $display("FAIL lh_misaligned got en=%b rv=%b err=%b data=%h want 0 1 1 0", o.en, o.rv, o.err, o.data);
    else pass_count++;
    txn(1'b1, 1'b0, 2'd1, 1'b1, 32'h62, 32'h0, o);
    check_count++;
    if (o.data !== 32'h00001234 || o.err !== 1'b0) $display("FAIL lhu_readback got %h err=%b want 00001234 err=0", o.data, o.err);
    else pass_count++;
  endtask

  task automatic test_priority();
    logic got, g_ls, both, if_seen, last_was_ls, exp_ls;
    do_reset();
    @(posedge clock); #1;
    ls_req_valid = 1'b1; ls_req_we = 1'b0; ls_req_size = 2'd2; ls_req_unsigned = 1'b0; ls_req_addr = 32'h40;
    if_req_valid = 1'b1; if_req_addr = 32'h0;
    if_seen = 1'b0;
    last_was_ls = 1'b0;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0; g_ls = 1'b0; both = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
        #1;
        if (ls_req_ready || if_req_ready) begin
          got = 1'b1; g_ls = ls_req_ready; both = ls_req_ready && if_req_ready;
          if_seen = if_seen | if_req_ready;
        end else begin
          @(posedge clock); #1;
        end
      end
      exp_ls = RR ? !last_was_ls : 1'b1;
      $display("tie grant %0d -> %s", k, !got ? "none" : g_ls ? "ls" : "if");
      check_count++;
      if (!got || both || g_ls !== exp_ls)
        $display("FAIL tie_grant_%0d got acc=%b both=%b ls=%b want acc=1 both=0 ls=%b", k, got, both, g_ls, exp_ls);
      else pass_count++;
      last_was_ls = g_ls;
      @(posedge clock); #1;
    end
    ls_req_valid = 1'b0; if_req_valid = 1'b0;
    check_count++;
    if (if_seen !== RR) $display("FAIL tie_if_ready got %b want %b", if_seen, RR);
    else pass_count++;
    repeat (3) @(posedge clock);
  endtask

  task automatic test_reset_mid();
    logic got;
    @(posedge clock); #1;
    ls_req_valid = 1'b1; ls_req_we = 1'b0; ls_req_size = 2'd2; ls_req_unsigned = 1'b0; ls_req_addr = 32'h10;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      #1;
      if (ls_req_ready) got = 1'b1;
      else begin @(posedge clock); #1; end
    end
    check_count++;
    if (!got) $display("FAIL rstmid_accept got 0 want 1");
    else pass_count++;
    @(posedge clock); #1;
    ls_req_valid = 1'b0;
    reset = 1'b1; if_req_valid = 1'b1; if_req_addr = 32'h8;
    #1;
    check_count++;
    if (if_req_ready !== 1'b0 || mem_en !== 1'b0) $display("FAIL rstmid_quiet got ready=%b en=%b want 0 0", if_req_ready, mem_en);
    else pass_count++;
    @(posedge clock); #1;
    check_count++;
    if (ls_rsp_valid !== 1'b0 || ls_rsp_data !== 32'h0) $display("FAIL rstmid_drop got v=%b d=%h want 0 0", ls_rsp_valid, ls_rsp_data);
    else pass_count++;
    reset = 1'b0;
    #1;
    check_count++;
    if (if_req_ready !== 1'b1) $display("FAIL rstmid_first_idle got ready=%b want 1", if_req_ready);
    else pass_count++;
    @(posedge clock); #1;
    if_req_valid = 1'b0;
    @(posedge clock); #1;
    check_count++;
    if (if_rsp_valid !== 1'b1 || if_rsp_data !== model_read(2'd2, 1'b1, 32'h8) || ls_rsp_valid !== 1'b0)
      $display("FAIL rstmid_fetch got v=%b d=%h lsv=%b want 1 %h 0", if_rsp_valid, if_rsp_data, ls_rsp_valid, model_read(2'd2, 1'b1, 32'h8));
    else pass_count++;
    @(posedge clock); #1;
  endtask

  task automatic test_wrap();
    obs_t o;
    txn(1'b0, 1'b0, 2'd2, 1'b0, 32'h3FE, 32'h0, o);
    check_count++;
    if (o.en !== 1'b0 || !o.rv || o.err !== 1'b1 || o.data !== 32'h0) $display("FAIL fetch_misaligned got en=%b rv=%b err=%b data=%h want 0 1 1 0", o.en, o.rv, o.err, o.data);
    else pass_count++;
    txn(1'b0, 1'b0, 2'd2, 1'b0, 32'h400, 32'h0, o);
    check_count++;
    if (o.en !== 1'b1 || o.maddr !== 8'h00 || o.err !== 1'b0 || o.data !== model_read(2'd2, 1'b1, 32'h0))
      $display("FAIL fetch_wrap got en=%b addr=%h err=%b data=%h want 1 00 0 %h", o.en, o.maddr, o.err, o.data, model_read(2'd2, 1'b1, 32'h0));
    else pass_count++;
  endtask

  task automatic test_back_to_back(input int n);
    obs_t o;
    logic use_ls, we, uns, legal;
    logic [1:0] sz, esz;
    logic [31:0] a, wd, exp_data;
    logic [3:0] exp_strb;
    int nb;
    for (int i = 0; i < n; i++) begin
      use_ls = $urandom_range(0, 2) != 0;
      we     = use_ls && ($urandom_range(0, 1) == 1);
      sz     = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      uns    = $urandom_range(0, 1) == 1;
      a      = $urandom;
      wd     = $urandom;
      esz    = use_ls ? sz : 2'd2;
      if ($urandom_range(0, 3) != 0) begin
        if (esz == 2'd1) a[0] = 1'b0;
        else if (esz == 2'd2) a[1:0] = 2'b00;
      end
      legal    = legal_of(esz, a);
      nb       = nbytes_of(esz);
      exp_data = (legal && !we) ? model_read(esz, uns || !use_ls, a) : 32'h0;
      exp_strb = 4'b0000;
      if (legal && we) for (int k = 0; k < nb; k++) exp_strb[a[1:0] + 2'(k)] = 1'b1;

      txn(use_ls, we, sz, uns, a, wd, o);

      check_count++;
      if (!o.ok) $display("FAIL rnd%0d_accept got 0 want 1", i);
      else pass_count++;
      check_count++;
      if (o.en !== legal || o.we !== (legal && we) || o.strb !== exp_strb || o.maddr !== (legal ? a[9:2] : 8'h00))
        $display("FAIL rnd%0d_mem got en=%b we=%b strb=%b addr=%h want %b %b %b %h", i, o.en, o.we, o.strb, o.maddr,
                 legal, legal && we, exp_strb, legal ? a[9:2] : 8'h00);
      else pass_count++;
      if (legal && we) begin
        for (int k = 0; k < nb; k++) begin
          check_count++;
          if (o.wdata[8*(int'(a[1:0]) + k) +: 8] !== wd[8*k +: 8])
            $display("FAIL rnd%0d_wbyte%0d got %h want %h", i, k, o.wdata[8*(int'(a[1:0]) + k) +: 8], wd[8*k +: 8]);
          else pass_count++;
          mb[int'(a[9:0]) + k] = wd[8*k +: 8];
        end
      end
      check_count++;
      if (o.early !== 1'b0 || o.rv !== 1'b1 || o.other !== 1'b0 || o.late !== 1'b0)
        $display("FAIL rnd%0d_pulse got early=%b rv=%b other=%b late=%b want 0 1 0 0", i, o.early, o.rv, o.other, o.late);
      else pass_count++;
      check_count++;
      if (o.data !== exp_data || o.err !== !legal)
        $display("FAIL rnd%0d_rsp got data=%h err=%b want %h %b", i, o.data, o.err, exp_data, !legal);
      else pass_count++;
    end
  endtask

  initial begin
    check_count = 0;
    pass_count  = 0;
    reset = 1'b1;
    if_req_valid = 1'b0; if_req_addr = 32'h0;
    ls_req_valid = 1'b0; ls_req_addr = 32'h0; ls_req_we = 1'b0; ls_req_size = 2'd0;
    ls_req_unsigned = 1'b0; ls_req_wdata = 32'h0;
    pl_en = 1'b0; pl_addr = 8'h0; pl_data = 32'h0;

    for (int w = 0; w < 256; w++) preload(w, $urandom);

    test_reset();
    test_fetch();
    test_store_load_bytes();
    test_half();
    test_back_to_back(150);
    test_priority();
    test_reset_mid();
    test_wrap();
    test_back_to_back(40);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
